// File: rtl/if_id_buf_pkg.sv
// if_id_buf_pkg: shared width, NOP encoding and occupancy states for the IF/ID buffer.
package if_id_buf_pkg;
  localparam int WIDTH = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;
endpackage

// File: rtl/if_id_buf_entry.sv
// pipe_entry_reg: one valid bit plus pc/pc_plus_4/instr payload with load and clear.
// Clear drops only the valid bit; the payload keeps stale values.
module pipe_entry_reg #(
  parameter int XLEN = if_id_buf_pkg::WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus_4,
  input  logic [31:0]     i_instr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus_4,
  output logic [31:0]     o_instr
);
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus_4;
  logic [31:0]     r_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_pc_plus_4 <= '0;
      r_instr     <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid     <= 1'b1;
      r_pc        <= i_pc;
      r_pc_plus_4 <= i_pc_plus_4;
      r_instr     <= i_instr;
    end
  end

  assign o_valid     = r_valid;
  assign o_pc        = r_pc;
  assign o_pc_plus_4 = r_pc_plus_4;
  assign o_instr     = r_instr;
endmodule

// File: rtl/if_id_buf.sv
// if_id_buf: two-entry skid buffer between fetch and decode with flush on redirect.
// Optional stall/flush counters when IF_ID_BUF_PERF_EN is defined.
module if_id_buf #(
  parameter int          XLEN      = if_id_buf_pkg::WIDTH,
  parameter logic [31:0] NOP_INSTR = if_id_buf_pkg::NOP_INSTR
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc_plus_4,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus_4,
  output logic [31:0]     out_instr
`ifdef IF_ID_BUF_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);
  import if_id_buf_pkg::*;

  occ_e            r_state;
  occ_e            w_next;
  logic            w_accept;
  logic            w_consume;
  logic            w_main_load;
  logic            w_main_clear;
  logic            w_main_from_skid;
  logic            w_skid_load;
  logic            w_skid_clear;
  logic            w_main_valid;
  logic            w_skid_valid;
  logic [XLEN-1:0] w_main_pc;
  logic [XLEN-1:0] w_main_pc_plus_4;
  logic [31:0]     w_main_instr;
  logic [XLEN-1:0] w_skid_pc;
  logic [XLEN-1:0] w_skid_pc_plus_4;
  logic [31:0]     w_skid_instr;

  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= EMPTY;
    else          r_state <= w_next;
  end

  // Flush wins over everything; FULL never accepts because in_ready is low there.
  always_comb begin
    w_next           = r_state;
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_next       = EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          w_main_load = w_accept;
          w_next      = w_accept ? ONE : EMPTY;
        end
        ONE: begin
          w_main_load  = w_accept & w_consume;
          w_skid_load  = w_accept & ~w_consume;
          w_main_clear = w_consume & ~w_accept;
          w_next       = (w_accept & ~w_consume) ? FULL :
                         (w_consume & ~w_accept) ? EMPTY : ONE;
        end
        FULL: begin
          w_main_load      = w_consume;
          w_main_from_skid = w_consume;
          w_skid_clear     = w_consume;
          w_next           = w_consume ? ONE : FULL;
        end
        default: begin
          w_next       = EMPTY;
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  pipe_entry_reg #(.XLEN(XLEN)) u_main (
    .clk         (sys_clk),
    .rst_n       (sys_rst),
    .i_load      (w_main_load),
    .i_clear     (w_main_clear),
    .i_pc        (w_main_from_skid ? w_skid_pc : in_pc),
    .i_pc_plus_4 (w_main_from_skid ? w_skid_pc_plus_4 : in_pc_plus_4),
    .i_instr     (w_main_from_skid ? w_skid_instr : in_instr),
    .o_valid     (w_main_valid),
    .o_pc        (w_main_pc),
    .o_pc_plus_4 (w_main_pc_plus_4),
    .o_instr     (w_main_instr)
  );

  pipe_entry_reg #(.XLEN(XLEN)) u_skid (
    .clk         (sys_clk),
    .rst_n       (sys_rst),
    .i_load      (w_skid_load),
    .i_clear     (w_skid_clear),
    .i_pc        (in_pc),
    .i_pc_plus_4 (in_pc_plus_4),
    .i_instr     (in_instr),
    .o_valid     (w_skid_valid),
    .o_pc        (w_skid_pc),
    .o_pc_plus_4 (w_skid_pc_plus_4),
    .o_instr     (w_skid_instr)
  );

  assign in_ready      = ~w_skid_valid;
  assign out_valid     = w_main_valid;
  assign out_pc        = w_main_pc;
  assign out_pc_plus_4 = w_main_pc_plus_4;
  assign out_instr     = w_main_valid ? w_main_instr : NOP_INSTR;

`ifdef IF_ID_BUF_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Skid is never valid without main, so main valid means "any entry valid".
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_main_valid & ~out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush & w_main_valid)      r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_if_id_buf.sv
// tb_if_id_buf: directed stimulus with a scoreboard queue checked by a separate monitor.
module tb_if_id_buf;
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [31:0] ins;
  } ent_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [63:0] in_pc_plus_4 = '0;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [63:0] out_pc_plus_4;
  logic [31:0] out_instr;
`ifdef IF_ID_BUF_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int   total = 0;
  int   bad = 0;
  ent_t exp_q[$];

  if_id_buf dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_pc_plus_4  (in_pc_plus_4),
    .in_instr      (in_instr),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_pc_plus_4 (out_pc_plus_4),
    .out_instr     (out_instr)
`ifdef IF_ID_BUF_PERF_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Consumption happens at the next rising edge; sample at the falling edge before it.
  always @(negedge sys_clk) begin
    if (sys_rst && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected act=%h exp=none", out_pc);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_pc4", out_pc_plus_4, e.pc4);
        chk("sb_instr", {32'd0, out_instr}, {32'd0, e.ins});
      end
    end
  end

  task automatic send(input logic [63:0] pc, input logic [31:0] ins);
    in_valid = 1'b1;
    in_pc = pc;
    in_pc_plus_4 = pc + 64'd4;
    in_instr = ins;
    @(negedge sys_clk);
    if (in_ready && !flush) exp_q.push_back({pc, pc + 64'd4, ins});
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_flush(input logic iv, input logic [63:0] pc);
    flush = 1'b1;
    in_valid = iv;
    in_pc = pc;
    in_pc_plus_4 = pc + 64'd4;
    in_instr = 32'hBADBAD13;
    exp_q.delete();
    @(posedge sys_clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_empty(input string nm);
    chk({nm, "_ov"}, {63'd0, out_valid}, 64'd0);
    chk({nm, "_ir"}, {63'd0, in_ready}, 64'd1);
    chk({nm, "_nop"}, {32'd0, out_instr}, 64'h13);
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    exp_q.delete();
    #1;
    check_empty("rst");
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_pc4", out_pc_plus_4, 64'd0);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    do_reset();

    // streaming at full rate, one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(64'h8000_0000 + 64'(4 * i), 32'h0010_0093 + 32'(i));
      chk("stream_lat_ov", {63'd0, out_valid}, 64'd1);
      chk("stream_lat_pc", out_pc, 64'h8000_0000 + 64'(4 * i));
      chk("stream_ir", {63'd0, in_ready}, 64'd1);
    end
    idle(2);
    check_empty("drain");

    // stall fill
    out_ready = 1'b0;
    send(64'h100, 32'h0000_1111);
    send(64'h104, 32'h0000_2222);
    chk("fill_pc", out_pc, 64'h100);
    chk("fill_ir", {63'd0, in_ready}, 64'd0);
    send(64'h108, 32'h0000_3333);
    chk("fill_hold_pc", out_pc, 64'h100);
    out_ready = 1'b1;
    idle(1);
    chk("drain_b_pc", out_pc, 64'h104);
    chk("drain_b_ir", {63'd0, in_ready}, 64'd1);
    idle(2);
    check_empty("drain2");

    // flush priority while FULL
    out_ready = 1'b0;
    send(64'h180, 32'h0000_4444);
    send(64'h184, 32'h0000_5555);
    out_ready = 1'b1;
    do_flush(1'b1, 64'h200);
    check_empty("flush");
    idle(3);
    check_empty("post_flush");

    // accept + consume in ONE
    out_ready = 1'b0;
    send(64'h300, 32'h0000_6666);
    out_ready = 1'b1;
    send(64'h304, 32'h0000_7777);
    chk("ac_pc", out_pc, 64'h304);
    chk("ac_ov", {63'd0, out_valid}, 64'd1);
    chk("ac_ir", {63'd0, in_ready}, 64'd1);
    idle(2);

    // flush while empty is a no-op
    do_flush(1'b0, 64'h0);
    check_empty("flush_empty");

    // async reset mid-stream
    out_ready = 1'b0;
    send(64'h500, 32'h0000_8888);
    send(64'h504, 32'h0000_9999);
    #2;
    do_reset();

`ifdef IF_ID_BUF_PERF_EN
    chk("perf_rst_stall", {32'd0, stall_cnt}, 64'd0);
    chk("perf_rst_flush", {32'd0, flush_cnt}, 64'd0);
    out_ready = 1'b0;
    send(64'h400, 32'h0000_aaaa);
    idle(5);
    chk("perf_stall", {32'd0, stall_cnt}, 64'd5);
    do_flush(1'b0, 64'h0);
    send(64'h408, 32'h0000_bbbb);
    do_flush(1'b0, 64'h0);
    do_flush(1'b0, 64'h0);
    chk("perf_flush", {32'd0, flush_cnt}, 64'd2);
`endif

    out_ready = 1'b1;
    idle(3);
    chk("sb_left", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Two-entry skid-buffered pipeline register between the instruction fetch stage (ifu) and the decode stage (idu).
- Captures the fetched pc, pc_plus_4 and instruction behind a valid/ready handshake, so a decode stall never drops or duplicates an instruction.
- On a control-flow redirect (pc_sel from decode), it flushes everything in flight.
- Its outputs drive idu's now_pc, pc_plus_4 and instruction inputs.

Parameters:
- XLEN, 64, width of pc and pc_plus_4; matches `WIDTH from para.v.
- NOP_INSTR, 32'h0000_0013, instruction presented on out_instr when out_valid=0 (addi x0,x0,0).

Ports:
- sys_clk  in  1  single clock; all state updates on rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  ifu presents a fetched instruction.
- in_ready  out  1  buffer can accept this cycle; registered, no combinational path from out_ready.
- in_pc  in  XLEN  pc of the fetched instruction.
- in_pc_plus_4  in  XLEN  in_pc+4 from ifu.
- in_instr  in  32  fetched instruction word.
- flush  in  1  redirect (pc_sel taken); kills all buffered entries.
- out_valid  out  1  entry available to idu.
- out_ready  in  1  idu consumes the entry this cycle.
- out_pc  out  XLEN  pc of the head entry.
- out_pc_plus_4  out  XLEN  pc_plus_4 of the head entry.
- out_instr  out  32  head instruction, or NOP_INSTR when out_valid=0.

Behaviour:
- Storage:
  - main register (head, drives the outputs) and skid register, each with a valid bit.
  - Occupancy state: EMPTY (neither valid), ONE (main only), FULL (main+skid). The skid valid bit alone is illegal.
- Handshake: accept = in_valid & in_ready; consume = out_valid & out_ready.
- in_ready = ~skid_valid. It is a register bit, so the ready path carries no combinational dependence on out_ready.
- out_valid = main_valid.
- Transitions (no flush):
  - EMPTY + accept -> ONE; data loads main.
  - ONE + accept & consume -> ONE; main reloaded with new data.
  - ONE + accept & ~consume -> FULL; data loads skid.
  - ONE + consume & ~accept -> EMPTY.
  - FULL + consume -> ONE; skid moves to main. No accept is possible in FULL, since in_ready=0.
  - FULL + ~consume -> FULL; all registers hold.
- Latency: an accept in cycle N gives out_valid in cycle N+1 with the same pc/instr. Sustained throughput is 1/cycle while out_ready=1.
- Ordering: strict FIFO; skid contents always follow main contents.
- Flush:
  - Has priority over accept and consume in the same cycle.
  - Next edge: both valid bits = 0, state EMPTY, in_ready=1. Data fields may keep stale values; out_instr is forced to NOP_INSTR by valid=0.
  - An instruction presented with in_valid in the flush cycle is discarded.
  - A flush while EMPTY is a no-op.
- Reset (sys_rst=0, async):
  - Output values: out_valid=0, in_ready=1, out_pc=0, out_pc_plus_4=0, out_instr=NOP_INSTR.
  - Internal: skid cleared, state EMPTY.
  - Reset mid-operation discards all entries with no partial state.
  - Release is synchronous to sys_clk at the next edge.
- Data registers only load on accept or skid->main transfer. Values presented while out_valid=0 or in_ready=0 are don't-care to the other side.

Optional Feature:
- Macro IF_ID_BUF_PERF_EN.
- Defined:
  - Adds outputs stall_cnt [31:0] and flush_cnt [31:0], both reset to 0 and wrapping at 2^32.
  - stall_cnt increments each cycle out_valid & ~out_ready.
  - flush_cnt increments each cycle flush=1 and at least one entry is valid.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header (para.v):
  - `WIDTH.
  - NOP_INSTR constant.
  - Occupancy state encodings (EMPTY=2'd0, ONE=2'd1, FULL=2'd2).
- One sub-module, pipe_entry_reg: a valid bit plus pc/pc_plus_4/instr payload with load/clear. It is instantiated twice, for main and skid.

Test Plan:
- Reset: hold sys_rst=0 for 3 cycles, assert mid-stream -> out_valid=0, in_ready=1, out_instr=32'h13, out_pc=0 immediately (async).
- Streaming: out_ready=1, send pc 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles -> each appears on out_pc one cycle later in order; in_ready stays 1.
- Stall fill: out_ready=0, send A (pc 0x100) and B (pc 0x104) -> out_pc=0x100 held, in_ready=0 after B. Raise out_ready -> A, then B on the next cycle, then in_ready=1.
- Flush priority: state FULL, assert flush with in_valid=1 (pc 0x200) and out_ready=1 -> next cycle out_valid=0, out_instr=32'h13, in_ready=1; pc 0x200 never appears.
- Simultaneous accept+consume in ONE: main holds 0x300, send 0x304 with out_ready=1 -> next cycle out_pc=0x304, state ONE, in_ready=1.
- IF_ID_BUF_PERF_EN: 5 stalled cycles with out_valid=1, then 2 flushes with entries valid -> stall_cnt=5, flush_cnt=2.
